// File: rtl/schmitt_trigger_unit.sv
// Per-neuron hysteretic spike generator: signed threshold compares, programmable
// thresholds, registered spike copy and saturating spike counter.
module schmitt_trigger_unit #(
    parameter int W             = 8,
    parameter int TH_HI_DEFAULT = 64,
    parameter int TH_LO_DEFAULT = 0,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [W-1:0]     potential,
    input  logic             spkblty_in,
    output logic             spk,
    output logic             spkblty_out,
    input  logic             en,
    input  logic             cfg_we,
    input  logic [W-1:0]     cfg_thr_hi,
    input  logic [W-1:0]     cfg_thr_lo,
    output logic [W-1:0]     thr_hi,
    output logic [W-1:0]     thr_lo,
    input  logic             cnt_clr,
    output logic             spk_q,
    output logic [CNT_W-1:0] spk_count
);

    localparam logic [W-1:0] LP_HI_RST = W'(TH_HI_DEFAULT);
    localparam logic [W-1:0] LP_LO_RST = W'(TH_LO_DEFAULT);

    logic [W-1:0]     r_thr_hi;
    logic [W-1:0]     r_thr_lo;
    logic             r_spk_q;
    logic [CNT_W-1:0] r_spk_count;

    logic w_hi;
    logic w_lo;
    logic w_cfg_ok;
    logic w_spk;
    logic w_cnt_sat;

    assign w_hi      = $signed(potential) >= $signed(r_thr_hi);
    assign w_lo      = $signed(potential) <= $signed(r_thr_lo);
    assign w_cfg_ok  = $signed(cfg_thr_lo) <= $signed(cfg_thr_hi);
    assign w_cnt_sat = &r_spk_count;

    assign w_spk = ~reset & en & spkblty_in & w_hi;

    // Between the thresholds neither compare fires, so the armed state holds.
    always_comb begin
        spkblty_out = spkblty_in;
        if (reset) begin
            spkblty_out = 1'b1;
        end else if (en) begin
            spkblty_out = spkblty_in ? ~w_hi : w_lo;
        end
    end

    // An inverted pair would make the hysteresis band meaningless, so drop it whole.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_thr_hi <= LP_HI_RST;
            r_thr_lo <= LP_LO_RST;
        end else if (cfg_we && w_cfg_ok) begin
            r_thr_hi <= cfg_thr_hi;
            r_thr_lo <= cfg_thr_lo;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_spk_q     <= 1'b0;
            r_spk_count <= '0;
        end else begin
            r_spk_q <= w_spk;
            if (cnt_clr) begin
                r_spk_count <= '0;
            end else if (w_spk && !w_cnt_sat) begin
                r_spk_count <= r_spk_count + 1'b1;
            end
        end
    end

    assign spk       = w_spk;
    assign thr_hi    = r_thr_hi;
    assign thr_lo    = r_thr_lo;
    assign spk_q     = r_spk_q;
    assign spk_count = r_spk_count;

endmodule

// File: tb/tb_schmitt_trigger_unit.sv
// Bench for schmitt_trigger_unit: directed plan steps plus random traffic, checked
// against an integer-arithmetic reference model.
module tb_schmitt_trigger_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  potential;
    logic        spkblty_in;
    logic        spk;
    logic        spkblty_out;
    logic        en;
    logic        cfg_we;
    logic [7:0]  cfg_thr_hi;
    logic [7:0]  cfg_thr_lo;
    logic [7:0]  thr_hi;
    logic [7:0]  thr_lo;
    logic        cnt_clr;
    logic        spk_q;
    logic [15:0] spk_count;

    schmitt_trigger_unit dut (
        .clk         (clk),
        .reset       (reset),
        .potential   (potential),
        .spkblty_in  (spkblty_in),
        .spk         (spk),
        .spkblty_out (spkblty_out),
        .en          (en),
        .cfg_we      (cfg_we),
        .cfg_thr_hi  (cfg_thr_hi),
        .cfg_thr_lo  (cfg_thr_lo),
        .thr_hi      (thr_hi),
        .thr_lo      (thr_lo),
        .cnt_clr     (cnt_clr),
        .spk_q       (spk_q),
        .spk_count   (spk_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state, plain integers.
    int m_hi   = 64;
    int m_lo   = 0;
    int m_cnt  = 0;
    int m_spkq = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: drive after negedge, check combinational outputs, clock, check registers.
    task automatic cycle(input int pot, input int sb, input int en_i, input int we,
                         input int chi, input int clo, input int clr, input int rst);
        int e_spk;
        int e_sbo;
        int hi_c;
        int lo_c;
        potential  = pot[7:0];
        spkblty_in = sb[0];
        en         = en_i[0];
        cfg_we     = we[0];
        cfg_thr_hi = chi[7:0];
        cfg_thr_lo = clo[7:0];
        cnt_clr    = clr[0];
        reset      = rst[0];
        #1;
        hi_c = (pot >= m_hi) ? 1 : 0;
        lo_c = (pot <= m_lo) ? 1 : 0;
        if (rst != 0) begin
            e_spk = 0;
            e_sbo = 1;
        end else begin
            e_spk = en_i & sb & hi_c;
            if (en_i == 0)   e_sbo = sb;
            else if (sb != 0) e_sbo = 1 - hi_c;
            else             e_sbo = lo_c;
        end
        check("spk", int'(spk), e_spk);
        check("spkblty_out", int'(spkblty_out), e_sbo);
        @(posedge clk);
        if (rst != 0) begin
            m_hi = 64; m_lo = 0; m_cnt = 0; m_spkq = 0;
        end else begin
            m_spkq = e_spk;
            if (we != 0 && clo <= chi) begin
                m_hi = chi;
                m_lo = clo;
            end
            if (clr != 0)       m_cnt = 0;
            else if (e_spk != 0) m_cnt = (m_cnt + 1 > 65535) ? 65535 : m_cnt + 1;
        end
        #1;
        check("thr_hi", int'($signed(thr_hi)), m_hi);
        check("thr_lo", int'($signed(thr_lo)), m_lo);
        check("spk_q", int'(spk_q), m_spkq);
        check("spk_count", int'(spk_count), m_cnt);
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; potential = '0; spkblty_in = 1'b1; en = 1'b0;
        cfg_we = 1'b0; cfg_thr_hi = '0; cfg_thr_lo = '0; cnt_clr = 1'b0;
        @(negedge clk);
        // reset state
        cycle(0, 1, 1, 0, 0, 0, 0, 1);
        cycle(0, 1, 1, 0, 0, 0, 0, 1);
        // default thresholds
        cycle(64, 1, 1, 0, 0, 0, 0, 0);
        cycle(63, 1, 1, 0, 0, 0, 0, 0);
        // hysteresis band and re-arm
        cycle(30, 0, 1, 0, 0, 0, 0, 0);
        cycle(0, 0, 1, 0, 0, 0, 0, 0);
        cycle(-5, 0, 1, 0, 0, 0, 0, 0);
        // accepted write, then use of new threshold
        cycle(0, 1, 1, 1, 20, -10, 0, 0);
        check("thr_hi_20", int'($signed(thr_hi)), 20);
        cycle(20, 1, 1, 0, 0, 0, 0, 0);
        // rejected inverted write
        cycle(0, 1, 1, 1, 5, 10, 0, 0);
        check("thr_lo_kept", int'($signed(thr_lo)), -10);
        cycle(19, 1, 1, 0, 0, 0, 0, 0);
        // signed extremes
        cycle(0, 1, 1, 1, -128, -128, 0, 0);
        cycle(-128, 1, 1, 0, 0, 0, 0, 0);
        cycle(-127, 0, 1, 0, 0, 0, 0, 0);
        cycle(0, 1, 1, 1, 64, 0, 0, 0);
        cycle(127, 1, 1, 0, 0, 0, 0, 0);
        // counter: clear, three spikes, spk_q lag
        cycle(0, 1, 1, 0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) cycle(100, 1, 1, 0, 0, 0, 0, 0);
        check("count_3", int'(spk_count), 3);
        cycle(0, 1, 1, 0, 0, 0, 0, 0);
        check("spk_q_after", int'(spk_q), 0);
        // clear together with a spike
        cycle(100, 1, 1, 0, 0, 0, 1, 0);
        check("clr_with_spk", int'(spk_count), 0);
        // disabled neuron passes armed state through
        cycle(127, 1, 0, 0, 0, 0, 0, 0);
        cycle(127, 0, 0, 0, 0, 0, 0, 0);
        // reset mid-operation drops a same-cycle write
        cycle(0, 1, 1, 1, 30, -30, 0, 0);
        cycle(127, 1, 1, 1, 10, -10, 0, 1);
        check("thr_hi_rst", int'($signed(thr_hi)), 64);
        // random traffic
        for (int i = 0; i < 400; i++) begin
            int lo_r;
            int hi_r;
            lo_r = $urandom_range(255) - 128;
            hi_r = $urandom_range(255) - 128;
            cycle($urandom_range(255) - 128, $urandom_range(1),
                  ($urandom_range(7) != 0) ? 1 : 0,
                  ($urandom_range(15) == 0) ? 1 : 0, hi_r, lo_r,
                  ($urandom_range(31) == 0) ? 1 : 0,
                  ($urandom_range(63) == 0) ? 1 : 0);
        end
        // saturation
        cycle(0, 1, 1, 1, 64, 0, 1, 0);
        for (int i = 0; i < 65540; i++) cycle(127, 1, 1, 0, 0, 0, 0, 0);
        check("count_sat", int'(spk_count), 65535);
        cycle(127, 1, 1, 0, 0, 0, 1, 0);
        check("count_clr_sat", int'(spk_count), 0);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule

// File: doc/schmitt_trigger_unit.md
Name:
schmitt_trigger_unit

Overview:
- Per-neuron spike generator with hysteresis for the SNN accelerator's spike processor; one instance per neuron.
- Compares an 8-bit signed membrane potential against a high and a low threshold.
- Emits a combinational spike and the next "spikability" (armed) state; the armed state is stored externally by the caller.
- Also provides programmable thresholds, a registered spike copy and a saturating spike counter.

Parameters:
- W, 8, potential/threshold width (two's complement)
- TH_HI_DEFAULT, 64, reset value of the high threshold
- TH_LO_DEFAULT, 0, reset value of the low threshold
- CNT_W, 16, spike counter width

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high reset
- potential  in  W  signed membrane potential
- spkblty_in  in  1  current armed state (1 = neuron may spike)
- spk  out  1  combinational spike
- spkblty_out  out  1  next armed state (combinational)
- en  in  1  neuron enable
- cfg_we  in  1  threshold write strobe
- cfg_thr_hi  in  W  new high threshold (signed)
- cfg_thr_lo  in  W  new low threshold (signed)
- thr_hi  out  W  current high threshold register
- thr_lo  out  W  current low threshold register
- cnt_clr  in  1  synchronous spike-counter clear
- spk_q  out  1  spk registered by one cycle
- spk_count  out  CNT_W  saturating spike count

Behaviour:
- Reset values: thr_hi=TH_HI_DEFAULT, thr_lo=TH_LO_DEFAULT, spk_q=0, spk_count=0.
- While reset=1: spk=0 and spkblty_out=1 (combinational override).
- Comparisons are signed, using the threshold registers: hi = potential >= thr_hi; lo = potential <= thr_lo.
- spk = en & spkblty_in & hi; no latency.
- spkblty_out:
  - en=0: spkblty_out = spkblty_in (pass-through).
  - spkblty_in=1: spkblty_out = ~hi (disarm on spike).
  - spkblty_in=0: spkblty_out = lo (re-arm only once potential falls to or below thr_lo).
  - Potential between the thresholds holds the current state; this is the hysteresis.
- Threshold write: on a clk edge with cfg_we=1, load both registers.
  - The write is accepted only if cfg_thr_lo <= cfg_thr_hi (signed).
  - Otherwise the whole write is ignored and both registers are unchanged.
  - New values affect spk from the next cycle.
- spk_q <= spk every cycle.
- spk_count priority: reset > cnt_clr > increment.
  - Increments when spk=1.
  - Saturates at all-ones and holds there; no wrap-around.
  - A clear and a spike in the same cycle result in 0.
- Reset mid-operation returns thresholds to their defaults; a write asserted in the same cycle as reset is dropped.
- Potential -128 and +127 are valid inputs; there is no overflow in the compares.

Test Plan:
- Defaults, en=1, spkblty_in=1, potential=64 -> spk=1, spkblty_out=0; potential=63 -> spk=0, spkblty_out=1.
- Hysteresis: spkblty_in=0, potential=30 -> spk=0, spkblty_out=0; potential=0 -> spkblty_out=1; potential=-5 -> spkblty_out=1.
- Config:
  - Write hi=20, lo=-10 -> next cycle thr_hi=20; potential=20 with spkblty_in=1 -> spk=1.
  - Write hi=5, lo=10 -> rejected, registers unchanged.
- Signed edges: thr_hi=-128 with potential=-128 and spkblty_in=1 -> spk=1; potential=127 with default thresholds -> spk=1.
- Counter:
  - 3 spike cycles -> spk_count=3, with spk_q lagging spk by one cycle.
  - Preload near saturation -> holds at 0xFFFF.
  - cnt_clr together with spk -> 0.
- en=0 with potential=127 -> spk=0, spkblty_out=spkblty_in; reset asserted -> spk=0, spkblty_out=1, then thresholds back to 64/0.
